// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state type, data width and default line timing.
package uart_pkg;

    localparam int DATA_W       = 8;
    localparam int TICK_W       = 5;
    localparam int CLOCK_PERIOD = 100;     // ns, 10 MHz system clock
    localparam int BAUD_RATE    = 115200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    // Value the parity bit must carry for the given byte.
    function automatic logic parity_of(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: samples bit centres on odd half-bit ticks, checks parity and
// framing, and hands complete bytes to a consumer through a one-deep holding register.
//
// state     | meaning
// ST_IDLE   | waiting for the tick generator enable to rise
// ST_START  | waiting for tick 1 to confirm the start bit is low
// ST_DATA   | shifting in D0..D7 at ticks 3..17
// ST_PARITY | sampling the parity bit at tick 19
// ST_STOP   | sampling the stop bit at tick 19 (21 with parity)
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              iCLK,
    input  logic              iRESETn,
    input  logic              iUART_RX,
    input  logic              iUART_RX_TICK,
    input  logic              iUART_RX_EN,
    input  logic              iUART_RX_READY,
    output logic              oUART_RX_STOP,
    output logic [DATA_W-1:0] oUART_RX_DATA,
    output logic              oUART_RX_VALID,
    output logic              oUART_RX_FERR,
    output logic              oUART_RX_PERR,
    output logic              oUART_RX_OVR
);

    localparam logic [TICK_W-1:0] TICK_START     = 5'd1;
    localparam logic [TICK_W-1:0] TICK_FIRST_BIT = 5'd3;
    localparam logic [TICK_W-1:0] TICK_LAST_BIT  = 5'd17;
    localparam logic [TICK_W-1:0] TICK_PARITY    = 5'd19;
    localparam logic [TICK_W-1:0] TICK_STOP      = PARITY_EN ? 5'd21 : 5'd19;

    rx_state_e         state_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] data_q;
    logic              en_q;
    logic              par_err_q;
    logic              valid_q;
    logic              stop_q;
    logic              ferr_q;
    logic              perr_q;
    logic              ovr_q;
    logic              en_rise;
    logic              mid_tick;

    // tick_cnt_d is the number of the tick arriving this cycle; odd numbers are bit centres.
    assign tick_cnt_d = tick_cnt_q + 5'd1;
    assign mid_tick   = iUART_RX_TICK && tick_cnt_d[0];
    assign en_rise    = iUART_RX_EN && !en_q;

    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            en_q       <= 1'b0;
            par_err_q  <= 1'b0;
            valid_q    <= 1'b0;
            stop_q     <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            en_q   <= iUART_RX_EN;
            stop_q <= 1'b0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
            ovr_q  <= 1'b0;

            if (valid_q && iUART_RX_READY) begin
                valid_q <= 1'b0;
            end

            if (!iUART_RX_EN) begin
                tick_cnt_q <= '0;
            end else if (iUART_RX_TICK) begin
                tick_cnt_q <= tick_cnt_d;
            end

            case (state_q)
                ST_IDLE: begin
                    if (en_rise) begin
                        state_q    <= ST_START;
                        tick_cnt_q <= '0;
                    end
                end
                ST_START: begin
                    if (!iUART_RX_EN) begin
                        state_q <= ST_IDLE;
                    end else if (mid_tick && tick_cnt_d == TICK_START) begin
                        if (iUART_RX) begin
                            stop_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            par_err_q <= 1'b0;
                            state_q   <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (!iUART_RX_EN) begin
                        state_q <= ST_IDLE;
                    end else if (mid_tick && tick_cnt_d >= TICK_FIRST_BIT) begin
                        shift_q <= {iUART_RX, shift_q[DATA_W-1:1]};
                        if (tick_cnt_d == TICK_LAST_BIT) begin
                            state_q <= PARITY_EN ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (!iUART_RX_EN) begin
                        state_q <= ST_IDLE;
                    end else if (mid_tick && tick_cnt_d == TICK_PARITY) begin
                        par_err_q <= (iUART_RX != parity_of(shift_q, PARITY_ODD));
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (!iUART_RX_EN) begin
                        state_q <= ST_IDLE;
                    end else if (mid_tick && tick_cnt_d == TICK_STOP) begin
                        stop_q  <= 1'b1;
                        state_q <= ST_IDLE;
                        ferr_q  <= !iUART_RX;
                        perr_q  <= par_err_q;
                        // A good byte never overwrites one the consumer has not taken.
                        if (iUART_RX && !par_err_q) begin
                            if (valid_q && !iUART_RX_READY) begin
                                ovr_q <= 1'b1;
                            end else begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oUART_RX_STOP  = stop_q;
    assign oUART_RX_DATA  = data_q;
    assign oUART_RX_VALID = valid_q;
    assign oUART_RX_FERR  = ferr_q;
    assign oUART_RX_PERR  = perr_q;
    assign oUART_RX_OVR   = ovr_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: two instances (no parity, even parity) driven with directed and
// random frames while the bench plays the tick generator; a byte-level model predicts results.
module tb_uart_rx_deser;

    localparam int HALF        = 43;
    localparam int FRAME_LIMIT = 25 * HALF + 20;
    localparam int M_NORMAL    = 0;
    localparam int M_GLITCH    = 1;
    localparam int M_ABORT     = 2;
    localparam int M_RESET     = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rx;
    logic [1:0] tick;
    logic [1:0] en;
    logic [1:0] ready;
    logic [1:0] stop;
    logic [1:0] valid;
    logic [1:0] ferr;
    logic [1:0] perr;
    logic [1:0] ovr;
    logic [7:0] data [2];

    int         n_vec = 0;
    int         n_bad = 0;
    logic       mdl_v [2];
    logic [7:0] mdl_d [2];

    always #5 clk = ~clk;

    uart_rx_deser #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
        .iCLK(clk), .iRESETn(rst_n), .iUART_RX(rx[0]), .iUART_RX_TICK(tick[0]),
        .iUART_RX_EN(en[0]), .iUART_RX_READY(ready[0]), .oUART_RX_STOP(stop[0]),
        .oUART_RX_DATA(data[0]), .oUART_RX_VALID(valid[0]), .oUART_RX_FERR(ferr[0]),
        .oUART_RX_PERR(perr[0]), .oUART_RX_OVR(ovr[0])
    );

    uart_rx_deser #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
        .iCLK(clk), .iRESETn(rst_n), .iUART_RX(rx[1]), .iUART_RX_TICK(tick[1]),
        .iUART_RX_EN(en[1]), .iUART_RX_READY(ready[1]), .oUART_RX_STOP(stop[1]),
        .oUART_RX_DATA(data[1]), .oUART_RX_VALID(valid[1]), .oUART_RX_FERR(ferr[1]),
        .oUART_RX_PERR(perr[1]), .oUART_RX_OVR(ovr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One frame on instance d. mode: normal, glitch (false start), abort (EN drops after
    // cut_tick), reset (iRESETn pulsed together with tick cut_tick).
    task automatic run_frame(input int d, input logic [7:0] byte_v, input int mode,
                             input int cut_tick, input logic stop_bit, input logic par_bit,
                             input logic rdy);
        logic [11:0] bits;
        logic        pe, good, exp_stop, exp_ferr, exp_perr, exp_ovr, exp_v_stop;
        logic        en_live, after_pending, rst_hit, v_at_stop, v_after;
        logic [7:0]  exp_d_stop, d_at_stop;
        logic [2:0]  err_at_stop;
        int          ticks, n_stop, n_ferr, n_perr, n_ovr, stop_tick, exp_tick, tail, idx;

        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = byte_v;
        if (d == 1) begin
            bits[9]  = par_bit;
            bits[10] = stop_bit;
        end else begin
            bits[9] = stop_bit;
        end

        pe       = (d == 1) && (par_bit != (^byte_v));
        exp_stop = (mode == M_NORMAL) || (mode == M_GLITCH);
        exp_tick = (mode == M_GLITCH) ? 1 : ((d == 1) ? 21 : 19);
        exp_ferr = (mode == M_NORMAL) && !stop_bit;
        exp_perr = (mode == M_NORMAL) && pe;
        good     = (mode == M_NORMAL) && stop_bit && !pe;
        exp_ovr  = 1'b0;

        ready[d] = rdy;
        for (int i = 0; i < 2; i++) begin
            if (ready[i]) mdl_v[i] = 1'b0;
        end
        if (good) begin
            if (mdl_v[d] && !rdy) begin
                exp_ovr = 1'b1;
            end else begin
                mdl_v[d] = 1'b1;
                mdl_d[d] = byte_v;
            end
        end
        exp_v_stop = mdl_v[d];
        exp_d_stop = mdl_d[d];

        ticks = 0; n_stop = 0; n_ferr = 0; n_perr = 0; n_ovr = 0;
        stop_tick = -1; tail = 3; en_live = 1'b1; after_pending = 1'b0; rst_hit = 1'b0;
        v_at_stop = 1'b0; v_after = 1'b0; d_at_stop = '0; err_at_stop = '0;
        en[d] = 1'b1;

        for (int k = 0; k < FRAME_LIMIT && tail > 0; k++) begin
            if (en_live) begin
                idx = k / (2 * HALF);
                if (mode == M_GLITCH) rx[d] = (k >= 20);
                else                  rx[d] = (idx < 12) ? bits[idx] : 1'b1;
                tick[d] = (k > 0) && (k % HALF == 0);
                if (tick[d]) ticks++;
                if (mode == M_ABORT && k == cut_tick * HALF + 10) en[d] = 1'b0;
                if (mode == M_RESET && k == cut_tick * HALF) begin
                    rst_n   = 1'b0;
                    rst_hit = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (rst_hit) begin
                rst_hit = 1'b0;
                rst_n   = 1'b1;
                en[d]   = 1'b0;
                chk("rst_stop",  stop[d],  0);
                chk("rst_valid", valid[d], 0);
                chk("rst_data",  data[d],  0);
                chk("rst_errs",  {ferr[d], perr[d], ovr[d]}, 0);
                chk("rst_other_valid", valid[1-d], 0);
                for (int i = 0; i < 2; i++) begin
                    mdl_v[i] = 1'b0;
                    mdl_d[i] = '0;
                end
            end
            if (after_pending) begin
                v_after       = valid[d];
                after_pending = 1'b0;
            end
            n_stop += int'(stop[d]);
            n_ferr += int'(ferr[d]);
            n_perr += int'(perr[d]);
            n_ovr  += int'(ovr[d]);
            if (stop[d] && stop_tick < 0) begin
                stop_tick     = ticks;
                v_at_stop     = valid[d];
                d_at_stop     = data[d];
                err_at_stop   = {ferr[d], perr[d], ovr[d]};
                en[d]         = 1'b0;
                after_pending = 1'b1;
            end
            if (!en[d]) begin
                en_live = 1'b0;
                rx[d]   = 1'b1;
                tick[d] = 1'b0;
                tail--;
            end
        end

        chk("stop_count", n_stop, exp_stop);
        if (exp_stop) chk("stop_tick", stop_tick, exp_tick);
        chk("ferr_count", n_ferr, exp_ferr);
        chk("perr_count", n_perr, exp_perr);
        chk("ovr_count",  n_ovr,  exp_ovr);
        if (mode == M_NORMAL) begin
            chk("errs_at_stop",  err_at_stop, {exp_ferr, exp_perr, exp_ovr});
            chk("valid_at_stop", v_at_stop, exp_v_stop);
            if (exp_v_stop) chk("data_at_stop", d_at_stop, exp_d_stop);
            chk("valid_after_stop", v_after, exp_v_stop && !rdy);
        end
        if (rdy) mdl_v[d] = 1'b0;
        chk("valid_idle", valid[d], mdl_v[d]);
        if (mdl_v[d]) chk("data_idle", data[d], mdl_d[d]);
    endtask

    initial begin
        int         sel, mode, cut;
        logic [7:0] b;
        logic       sb, pb, rdy;

        rst_n = 1'b0;
        rx    = 2'b11;
        tick  = 2'b00;
        en    = 2'b00;
        ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            mdl_v[i] = 1'b0;
            mdl_d[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_valid", valid[i], 0);
            chk("reset_data",  data[i],  0);
            chk("reset_pulses", {stop[i], ferr[i], perr[i], ovr[i]}, 0);
        end

        run_frame(0, 8'hA5, M_NORMAL, 0, 1'b1, 1'b0, 1'b1);
        run_frame(0, 8'h00, M_GLITCH, 0, 1'b1, 1'b0, 1'b1);
        run_frame(0, 8'h3C, M_NORMAL, 0, 1'b0, 1'b0, 1'b1);
        run_frame(1, 8'h07, M_NORMAL, 0, 1'b1, 1'b0, 1'b1);
        run_frame(1, 8'h07, M_NORMAL, 0, 1'b1, 1'b1, 1'b1);

        run_frame(0, 8'h11, M_NORMAL, 0, 1'b1, 1'b0, 1'b0);
        run_frame(0, 8'h22, M_NORMAL, 0, 1'b1, 1'b0, 1'b0);
        ready[0] = 1'b1;
        @(posedge clk);
        #1;
        mdl_v[0] = 1'b0;
        chk("drain_valid", valid[0], mdl_v[0]);
        chk("drain_data_kept", data[0], mdl_d[0]);

        run_frame(0, 8'hFF, M_RESET, 9, 1'b1, 1'b0, 1'b1);
        run_frame(0, 8'h5A, M_NORMAL, 0, 1'b1, 1'b0, 1'b1);
        run_frame(0, 8'hC3, M_ABORT, 7, 1'b1, 1'b0, 1'b1);
        run_frame(0, 8'h81, M_NORMAL, 0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            sel  = int'($urandom_range(0, 1));
            b    = 8'($urandom);
            sb   = ($urandom_range(0, 7) != 0);
            pb   = (^b) ^ ($urandom_range(0, 3) == 0);
            rdy  = 1'($urandom_range(0, 1));
            cut  = int'($urandom_range(1, 17));
            case ($urandom_range(0, 7))
                0:       mode = M_GLITCH;
                1:       mode = M_ABORT;
                default: mode = M_NORMAL;
            endcase
            run_frame(sel, b, mode, cut, sb, pb, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 SHALL have parameter PARITY_EN, default 0, meaning 1 = one parity bit between D7 and stop.
REQ-002 SHALL have parameter PARITY_ODD, default 0, meaning 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-003 SHALL have port iCLK, input, 1, single clock for all logic.
REQ-004 SHALL have port iRESETn, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port iUART_RX, input, 1, serial line, already synchronised upstream, idle high.
REQ-006 SHALL have port iUART_RX_TICK, input, 1, half-bit tick pulse from the tick generator.
REQ-007 SHALL have port iUART_RX_EN, input, 1, tick-generator enable (frame in progress).
REQ-008 SHALL have port iUART_RX_READY, input, 1, consumer accepts data when high with oUART_RX_VALID.
REQ-009 SHALL have port oUART_RX_STOP, output, 1, one-cycle end-of-frame pulse returned to the tick generator.
REQ-010 SHALL have port oUART_RX_DATA, output, 8, received byte.
REQ-011 SHALL have port oUART_RX_VALID, output, 1, oUART_RX_DATA holds an unconsumed byte.
REQ-012 SHALL have port oUART_RX_FERR, output, 1, one-cycle pulse: stop bit sampled low.
REQ-013 SHALL have port oUART_RX_PERR, output, 1, one-cycle pulse: parity mismatch.
REQ-014 SHALL have port oUART_RX_OVR, output, 1, one-cycle pulse: completed byte dropped because the holding register was full.

Function
REQ-015 Ticks SHALL be counted while iUART_RX_EN=1; tick number 2n+1 (1,3,5,...) is the centre of bit n; even-numbered ticks SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE->START on iUART_RX_EN rising (tick count cleared to 0).
REQ-018 START, on tick 1: iUART_RX=0 -> DATA; iUART_RX=1 -> false start, pulse oUART_RX_STOP, -> IDLE, no other output.
REQ-019 DATA SHALL sample 8 bits LSB first at ticks 3,5,...,17 into a shift register; after bit 7 -> PARITY if PARITY_EN else STOP.
REQ-020 PARITY SHALL sample at tick 19; mismatch against XOR of data (inverted when PARITY_ODD) is latched as the parity error; -> STOP.
REQ-021 STOP SHALL sample at tick 19 (21 with parity); the next cycle oUART_RX_STOP=1 for exactly one cycle; FSM -> IDLE.
REQ-022 Stop sample low SHALL pulse oUART_RX_FERR with oUART_RX_STOP and discard the byte; parity error SHALL pulse oUART_RX_PERR with oUART_RX_STOP and discard the byte.
REQ-023 A good frame SHALL load oUART_RX_DATA and set oUART_RX_VALID in the same cycle that oUART_RX_STOP is high.
REQ-024 oUART_RX_VALID SHALL clear on the cycle after VALID&READY, unless a new byte loads in that cycle, in which case it stays 1 with the new data.
REQ-025 A good frame completing while VALID=1 and READY=0 SHALL pulse oUART_RX_OVR, keep the old data and drop the new byte.
REQ-026 iUART_RX_EN falling outside STOP/false-start handling SHALL abort to IDLE without outputs other than clearing the tick count.
REQ-027 oUART_RX_DATA SHALL be stable while VALID=1.

Reset
REQ-028 With iRESETn=0 at a clock edge: FSM=IDLE, tick count=0, shift register=0, oUART_RX_DATA=0x00, and VALID, STOP, FERR, PERR, OVR all =0; a frame in progress SHALL be discarded.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state typedef, data width 8, and CLOCK_PERIOD/BAUD_RATE defaults.
REQ-030 Top-level uart_rx SHALL instantiate the tick generator and uart_rx_deser; the deserializer itself has no sub-module.

Verification (10 MHz, 115200 baud, 86 clk/bit, tick every 43 clk)
REQ-031 Frame 0xA5, stop=1, READY=1 -> DATA=0xA5, VALID one cycle, STOP pulse ~19*43 clk after start edge, no errors.
REQ-032 Glitch low 20 clk then high -> STOP pulse at tick 1, VALID, FERR and PERR remain 0.
REQ-033 Frame 0x3C with stop=0 -> FERR and STOP pulse together, VALID stays 0.
REQ-034 PARITY_EN=1, even parity, byte 0x07 with parity bit 0 -> PERR pulse; with parity bit 1 -> VALID, DATA=0x07.
REQ-035 READY=0, frames 0x11 then 0x22 -> DATA=0x11 held, OVR pulse on second STOP; READY=1 then clears VALID.
REQ-036 iRESETn=0 at tick 9 of frame 0xFF -> all outputs 0; next frame 0x5A received correctly.
